// File: rtl/bsg_fsb_murn_node_sequencer_pkg.sv
// Package for the FSB murn node sequencer.
// Holds the sequencer state encoding, the per-node step opcodes and the
// switch-flag bit position helper.
// Optional feature macro: BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
// (adds the SHUT state used by the reverse-order shutdown walk).
package bsg_fsb_murn_node_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    GAP  = 3'd2,
    DONE = 3'd3
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
    , SHUT = 3'd4
`endif
  } seq_state_e;

  // {enable, reset} pair carried in the low two packet bits
  typedef struct packed {
    logic en;
    logic rst;
  } step_op_t;

  localparam step_op_t STEP0_OP = '{en: 1'b0, rst: 1'b1};  // hold reset
  localparam step_op_t STEP1_OP = '{en: 1'b1, rst: 1'b1};  // enable under reset
  localparam step_op_t STEP2_OP = '{en: 1'b1, rst: 1'b0};  // release reset
  localparam step_op_t SHUT_OP  = STEP0_OP;                // shutdown parks the node

  localparam logic [1:0] LAST_STEP = 2'd2;

  function automatic step_op_t step_op(input logic [1:0] step);
    step_op_t op;
    case (step)
      2'd0:    op = STEP0_OP;
      2'd1:    op = STEP1_OP;
      2'd2:    op = STEP2_OP;
      default: op = STEP0_OP;
    endcase
    return op;
  endfunction

  // Switch-command flag sits directly below the node id field
  function automatic int switch_flag_pos(input int width, input int id_width);
    return width - 1 - id_width;
  endfunction

endpackage

// File: rtl/bsg_fsb_murn_switch_pkt_gen.sv
// Combinational formatter for FSB murn switch-command packets.
// Ports:
//   id_i   - destination node id
//   en_i   - enable value placed in bit 1
//   rst_i  - reset value placed in bit 0
//   data_o - formatted packet: {id, switch flag=1, zero pad, en, rst}
module bsg_fsb_murn_switch_pkt_gen
  import bsg_fsb_murn_node_sequencer_pkg::*;
  #(parameter int width_p    = 64
   ,parameter int id_width_p = 4
   )
  (input  logic [id_width_p-1:0] id_i
  ,input  logic                  en_i
  ,input  logic                  rst_i
  ,output logic [width_p-1:0]    data_o
  );

  localparam int sw_pos_lp    = switch_flag_pos(width_p, id_width_p);
  localparam int pad_width_lp = sw_pos_lp - 2;

  typedef struct packed {
    logic [id_width_p-1:0]   id;
    logic                    sw;
    logic [pad_width_lp-1:0] pad;
    logic                    en;
    logic                    rst;
  } hdr_t;

  hdr_t hdr_s;

  // Pack the header fields; everything not named stays zero
  always_comb begin
    hdr_s     = '0;
    hdr_s.id  = id_i;
    hdr_s.sw  = 1'b1;
    hdr_s.en  = en_i;
    hdr_s.rst = rst_i;
    data_o    = hdr_s;
  end

endmodule

// File: rtl/bsg_fsb_murn_node_sequencer.sv
// Brings up a chain of FSB murn gateway nodes in order by issuing three
// switch commands per node (hold reset, enable, release reset) on an FSB
// ready/valid (v/yumi) link, with a fixed idle gap after every accepted
// command except the last.
// Ports:
//   clk_i, reset_i - clock, synchronous active-high reset
//   start_i        - begins (or restarts from DONE) the bring-up sequence
//   stop_i         - (shutdown build only) in DONE, parks all nodes in reverse
//   v_o, data_o    - packet valid / packet (zero when not valid)
//   yumi_i         - consumer takes data_o this cycle
//   busy_o, done_o - sequence in progress / all nodes up (sticky)
//   node_idx_o     - index of the node currently being sequenced
// Optional feature macro: BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
module bsg_fsb_murn_node_sequencer
  import bsg_fsb_murn_node_sequencer_pkg::*;
  #(parameter int width_p      = 64
   ,parameter int id_width_p   = 4
   ,parameter int num_nodes_p  = 4
   ,parameter int first_id_p   = 0
   ,parameter int gap_cycles_p = 8
   )
  (input  logic                               clk_i
  ,input  logic                               reset_i
  ,input  logic                               start_i
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
  ,input  logic                               stop_i
`endif
  ,output logic                               v_o
  ,output logic [width_p-1:0]                 data_o
  ,input  logic                               yumi_i
  ,output logic                               busy_o
  ,output logic                               done_o
  ,output logic [$clog2(num_nodes_p+1)-1:0]   node_idx_o
  );

  localparam int                   node_w_lp    = $clog2(num_nodes_p+1);
  localparam logic [node_w_lp-1:0] last_node_lp = node_w_lp'(num_nodes_p-1);
  localparam int                   gap_w_lp     = (gap_cycles_p > 1) ? $clog2(gap_cycles_p) : 1;
  localparam logic [gap_w_lp-1:0]  gap_init_lp  = (gap_cycles_p > 0) ? gap_w_lp'(gap_cycles_p-1) : '0;
  localparam bit                   gap_en_lp    = (gap_cycles_p > 0);

  seq_state_e            state_r, state_s;
  logic [node_w_lp-1:0]  node_r, node_s;
  logic [1:0]            step_r, step_s;
  logic [gap_w_lp-1:0]   gap_cnt_r, gap_cnt_s;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
  logic                  shut_r, shut_s;  // GAP returns to SHUT rather than SEND
`endif

  logic                  v_s, busy_s, done_s;
  step_op_t              op_s;
  logic [id_width_p-1:0] id_s;
  logic [width_p-1:0]    pkt_s;

  // State register and sequencing counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      node_r    <= '0;
      step_r    <= 2'd0;
      gap_cnt_r <= '0;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
      shut_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      node_r    <= node_s;
      step_r    <= step_s;
      gap_cnt_r <= gap_cnt_s;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
      shut_r    <= shut_s;
`endif
    end
  end

  // Next-state logic: handshake advance, gap countdown, start/stop decode
  always_comb begin
    state_s   = state_r;
    node_s    = node_r;
    step_s    = step_r;
    gap_cnt_s = gap_cnt_r;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
    shut_s    = shut_r;
`endif
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = SEND;
          node_s  = '0;
          step_s  = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if ((node_r == last_node_lp) && (step_r == LAST_STEP)) begin
            state_s = DONE;
          end else begin
            if (step_r == LAST_STEP) begin
              step_s = 2'd0;
              node_s = node_r + node_w_lp'(1'b1);
            end else begin
              step_s = step_r + 2'd1;
            end
            if (gap_en_lp) begin
              state_s   = GAP;
              gap_cnt_s = gap_init_lp;
            end else begin
              state_s = SEND;
            end
          end
        end else begin
          state_s = SEND;
        end
      end
      GAP: begin
        if (gap_cnt_r == '0) begin
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
          if (shut_r) begin
            state_s = SHUT;
          end else begin
            state_s = SEND;
          end
`else
          state_s = SEND;
`endif
        end else begin
          gap_cnt_s = gap_cnt_r - gap_w_lp'(1'b1);
        end
      end
      DONE: begin
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
        // stop_i takes priority over start_i
        if (stop_i) begin
          state_s = SHUT;
          node_s  = last_node_lp;
          step_s  = 2'd0;
          shut_s  = 1'b1;
        end else if (start_i) begin
          state_s = SEND;
          node_s  = '0;
          step_s  = 2'd0;
        end else begin
          state_s = DONE;
        end
`else
        if (start_i) begin
          state_s = SEND;
          node_s  = '0;
          step_s  = 2'd0;
        end else begin
          state_s = DONE;
        end
`endif
      end
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
      SHUT: begin
        if (yumi_i) begin
          if (node_r == '0) begin
            state_s = IDLE;
            shut_s  = 1'b0;
          end else begin
            node_s = node_r - node_w_lp'(1'b1);
            if (gap_en_lp) begin
              state_s   = GAP;
              gap_cnt_s = gap_init_lp;
            end else begin
              state_s = SHUT;
            end
          end
        end else begin
          state_s = SHUT;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so v_o/data_o never see yumi_i
  always_comb begin
    v_s    = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    op_s   = '0;
    case (state_r)
      SEND: begin
        v_s    = 1'b1;
        busy_s = 1'b1;
        op_s   = step_op(step_r);
      end
      GAP: begin
        busy_s = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
      SHUT: begin
        v_s    = 1'b1;
        busy_s = 1'b1;
        op_s   = SHUT_OP;
      end
`endif
      default: begin
        v_s = 1'b0;
      end
    endcase
  end

  // Node id wraps naturally at id_width_p bits
  assign id_s = id_width_p'(first_id_p) + id_width_p'(node_r);

  bsg_fsb_murn_switch_pkt_gen
    #(.width_p   (width_p)
     ,.id_width_p(id_width_p)
     )
    pkt_gen
    (.id_i  (id_s)
    ,.en_i  (op_s.en)
    ,.rst_i (op_s.rst)
    ,.data_o(pkt_s)
    );

  // Drive the link; the packet bus is held at zero while not valid
  always_comb begin
    if (v_s) begin
      data_o = pkt_s;
    end else begin
      data_o = '0;
    end
  end

  assign v_o        = v_s;
  assign busy_o     = busy_s;
  assign done_o     = done_s;
  assign node_idx_o = node_r;

endmodule

// File: tb/tb_bsg_fsb_murn_node_sequencer.sv
module tb_bsg_fsb_murn_node_sequencer;

  // Hand-computed bring-up packets: nibble 15 = id, bit 59 = switch flag
  localparam logic [63:0] SEQ_PKTS [0:11] = '{
    64'h0800_0000_0000_0001, 64'h0800_0000_0000_0003, 64'h0800_0000_0000_0002,
    64'h1800_0000_0000_0001, 64'h1800_0000_0000_0003, 64'h1800_0000_0000_0002,
    64'h2800_0000_0000_0001, 64'h2800_0000_0000_0003, 64'h2800_0000_0000_0002,
    64'h3800_0000_0000_0001, 64'h3800_0000_0000_0003, 64'h3800_0000_0000_0002};
  localparam logic [63:0] STALL_PKT = 64'h1800_0000_0000_0003;

  typedef struct {
    logic [63:0] data;
    int          idx;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_a, start_b, yumi_a, yumi_b;
  logic        v_a, busy_a, done_a, v_b, busy_b, done_b;
  logic [63:0] data_a, data_b;
  logic [2:0]  idx_a;
  logic [1:0]  idx_b;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
  logic        stop_a, stop_b;
`endif

  exp_t q_a[$], q_b[$];
  exp_t ea, eb;
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, t0_a = 0, t0_b = 0;
  int   stall_left = 0;
  bit   stall_on = 1'b0;

  bsg_fsb_murn_node_sequencer #(.width_p(64), .id_width_p(4), .num_nodes_p(4),
                                .first_id_p(0), .gap_cycles_p(8)) dut_a
    (.clk_i(clk), .reset_i(reset), .start_i(start_a),
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
     .stop_i(stop_a),
`endif
     .v_o(v_a), .data_o(data_a), .yumi_i(yumi_a), .busy_o(busy_a),
     .done_o(done_a), .node_idx_o(idx_a));

  bsg_fsb_murn_node_sequencer #(.width_p(64), .id_width_p(4), .num_nodes_p(2),
                                .first_id_p(0), .gap_cycles_p(0)) dut_b
    (.clk_i(clk), .reset_i(reset), .start_i(start_b),
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
     .stop_i(stop_b),
`endif
     .v_o(v_b), .data_o(data_b), .yumi_i(yumi_b), .busy_o(busy_b),
     .done_o(done_b), .node_idx_o(idx_b));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input int shift_from, input int shift);
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      e.data = SEQ_PKTS[k];
      e.idx  = k / 3;
      e.cyc  = 1 + 9 * k + ((k >= shift_from) ? shift : 0);
      q_a.push_back(e);
    end
  endtask

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    t0_a = cyc;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input int exp_cyc);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) found = 1'b1;
    end
    start_a = 1'b0;
    if (found) begin
      chk("done_a_cycle", 64'(cyc - t0_a), 64'(exp_cyc));
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL done_a_timeout: got done_o=%0b, expected 1 within %0d cycles", done_a, budget);
    end
  endtask

  // Consumer for A: accept immediately except for a 5-cycle stall window
  initial begin
    yumi_a = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_left > 0 && (stall_on || (v_a === 1'b1 && data_a === STALL_PKT))) begin
        stall_on = 1'b1;
        yumi_a   = 1'b0;
        chk("stall_v", 64'(v_a), 64'd1);
        chk("stall_data", data_a, STALL_PKT);
        stall_left--;
      end else begin
        stall_on = 1'b0;
        yumi_a   = v_a;
      end
    end
  end

  // Consumer for B: always accept immediately
  initial begin
    yumi_b = 1'b0;
    forever begin
      @(negedge clk);
      yumi_b = v_b;
    end
  end

  // Monitor A: compare every handshake against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (v_a === 1'b1 && yumi_a === 1'b1) begin
        if (q_a.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pkt_a_extra: got 0x%0h, expected no packet", data_a);
        end else begin
          ea = q_a.pop_front();
          chk("pkt_a_data", data_a, ea.data);
          chk("pkt_a_idx", 64'(idx_a), 64'(ea.idx));
          chk("pkt_a_cycle", 64'(cyc - t0_a), 64'(ea.cyc));
        end
      end
    end
  end

  // Monitor B
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (v_b === 1'b1 && yumi_b === 1'b1) begin
        if (q_b.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pkt_b_extra: got 0x%0h, expected no packet", data_b);
        end else begin
          eb = q_b.pop_front();
          chk("pkt_b_data", data_b, eb.data);
          chk("pkt_b_idx", 64'(idx_b), 64'(eb.idx));
          chk("pkt_b_cycle", 64'(cyc - t0_b), 64'(eb.cyc));
        end
      end
    end
  end

  initial begin
    exp_t e;
    bit   found;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
    stop_a = 1'b0; stop_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_v", 64'(v_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_idx", 64'(idx_a), 64'd0);
    chk("rst_data", data_a, 64'd0);
    chk("rst_b_v", 64'(v_b), 64'd0);

    // N=2, G=0: six back-to-back packets at cycles 1..6, done at 7
    for (int k = 0; k < 6; k++) begin
      e.data = SEQ_PKTS[k]; e.idx = k / 3; e.cyc = 1 + k;
      q_b.push_back(e);
    end
    @(negedge clk);
    start_b = 1'b1;
    t0_b = cyc;
    @(negedge clk);
    start_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (done_b === 1'b1) found = 1'b1;
    end
    chk("done_b_seen", 64'(found), 64'd1);
    chk("done_b_cycle", 64'(cyc - t0_b), 64'd7);
    chk("q_b_drained", 64'(q_b.size()), 64'd0);

    // Full bring-up with immediate accept
    push_a(99, 0);
    pulse_a();
    wait_done_a(120, 101);
    repeat (2) begin
      @(negedge clk);
      chk("done_sticky", 64'(done_a), 64'd1);
      chk("done_not_busy", 64'(busy_a), 64'd0);
      chk("done_v_low", 64'(v_a), 64'd0);
    end
    chk("q_a_drained_1", 64'(q_a.size()), 64'd0);

    // Restart from DONE with start_i held high throughout
    push_a(99, 0);
    @(negedge clk);
    start_a = 1'b1;
    t0_a = cyc;
    @(negedge clk);
    chk("restart_done_clr", 64'(done_a), 64'd0);
    chk("restart_busy", 64'(busy_a), 64'd1);
    chk("restart_idx", 64'(idx_a), 64'd0);
    wait_done_a(120, 101);
    repeat (3) begin
      @(negedge clk);
      chk("held_start_done", 64'(done_a), 64'd1);
      chk("held_start_idle", 64'(busy_a), 64'd0);
    end
    chk("q_a_drained_2", 64'(q_a.size()), 64'd0);

    // Backpressure: stall node1 step1 for 5 cycles, later packets shift by 5
    stall_left = 5;
    push_a(4, 5);
    pulse_a();
    wait_done_a(130, 106);
    chk("stall_consumed", 64'(stall_left), 64'd0);
    chk("q_a_drained_3", 64'(q_a.size()), 64'd0);

    // Reset in the GAP after the third packet, then a clean run from node 0
    for (int k = 0; k < 3; k++) begin
      e.data = SEQ_PKTS[k]; e.idx = 0; e.cyc = 1 + 9 * k;
      q_a.push_back(e);
    end
    pulse_a();
    repeat (19) @(negedge clk);
    chk("mid_gap_busy", 64'(busy_a), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_v", 64'(v_a), 64'd0);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_done", 64'(done_a), 64'd0);
    chk("mid_rst_idx", 64'(idx_a), 64'd0);
    reset = 1'b0;
    chk("q_a_drained_4", 64'(q_a.size()), 64'd0);
    push_a(99, 0);
    pulse_a();
    wait_done_a(120, 101);

`ifdef BSG_FSB_MURN_NODE_SEQUENCER_SHUTDOWN_EN
    // Shutdown from DONE: stop_i wins over start_i, ids 3..0 each {en=0,rst=1}
    for (int k = 0; k < 4; k++) begin
      e.data = SEQ_PKTS[3 * (3 - k)]; e.idx = 3 - k; e.cyc = 1 + 9 * k;
      q_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b1;
    stop_a  = 1'b1;
    t0_a = cyc;
    @(negedge clk);
    start_a = 1'b0;
    stop_a  = 1'b0;
    chk("shut_busy", 64'(busy_a), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (busy_a === 1'b0) found = 1'b1;
    end
    chk("shut_end_seen", 64'(found), 64'd1);
    chk("shut_end_cycle", 64'(cyc - t0_a), 64'd29);
    chk("shut_done_clr", 64'(done_a), 64'd0);
    chk("shut_v_low", 64'(v_a), 64'd0);
    chk("q_a_drained_5", 64'(q_a.size()), 64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("q_a_final", 64'(q_a.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
